// File: rtl/uart_tx_fifo.sv
// UART transmitter with TX FIFO, configurable parity/stop bits and
// oversampled bit timing, driven from the iocs/iorw/ioaddr/databus port.
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int OVS        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          brg_full,
    input  logic                          iocs,
    input  logic                          iorw,
    input  logic [1:0]                    ioaddr,
    input  logic [7:0]                    databus,
    output logic                          tbr,
    output logic                          txd,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (OVS > 1) ? $clog2(OVS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic              ovf_q, ovf_d;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [2:0]        cfg_q, cfg_d;
    logic              par_q, par_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [2:0]        bit_q, bit_d;
    logic              txd_q, txd_d;
    logic              done_q, done_d;

    logic              wr_stb, full, empty, bit_end;
    logic              push, pop, go;
    logic [DATA_W-1:0] head;
    logic              unused_bits;

    assign unused_bits = ^databus[6:3];

    assign wr_stb  = iocs & ~iorw;
    assign full    = (cnt_q == CW'(FIFO_DEPTH));
    assign empty   = (cnt_q == '0);
    assign bit_end = brg_full && (tick_q == TW'(OVS - 1));
    assign head    = mem_q[rptr_q];

    // A full FIFO still accepts a write when the transmitter pops that cycle
    assign push = wr_stb && (ioaddr == 2'b00) && (!full || pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        ctrl_d = ctrl_q;
        ovf_d  = ovf_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        if (wr_stb && (ioaddr == 2'b00) && full && !pop) begin
            ovf_d = 1'b1;
        end
        if (wr_stb && (ioaddr == 2'b01)) begin
            ctrl_d = databus[2:0];
            if (databus[7]) begin
                ovf_d = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cfg_d   = cfg_q;
        par_d   = par_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        txd_d   = txd_q;
        done_d  = 1'b0;
        go      = 1'b0;
        pop     = 1'b0;

        if (state_q != IDLE && brg_full) begin
            tick_d = bit_end ? '0 : tick_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                txd_d  = 1'b1;
                tick_d = '0;
                go     = !empty;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    txd_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'(DATA_W - 1)) begin
                        bit_d = '0;
                        if (cfg_q[0]) begin
                            state_d = PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d = STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        txd_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                    bit_d   = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (cfg_q[2] && bit_q == 3'd0) begin
                        bit_d = 3'd1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                        txd_d   = 1'b1;
                        go      = !empty;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // Frame config is sampled only here, so mid-frame control writes wait
        if (go) begin
            pop     = 1'b1;
            state_d = START;
            shift_d = head;
            cfg_d   = ctrl_q;
            par_d   = (^head) ^ ctrl_q[1];
            tick_d  = '0;
            bit_d   = '0;
            txd_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= databus[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ctrl_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ctrl_q <= ctrl_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cfg_q   <= '0;
            par_q   <= 1'b0;
            tick_q  <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cfg_q   <= cfg_d;
            par_q   <= par_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
        end
    end

    assign tbr        = !full;
    assign txd        = txd_q;
    assign tx_busy    = (state_q != IDLE);
    assign tx_done    = done_q;
    assign fifo_count = cnt_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed frame tables, FIFO/overflow,
// reset and mid-frame control cases, then random traffic into a UART receiver model.
module tb_uart_tx_fifo;

    localparam int DW  = 8;
    localparam int DEP = 8;
    localparam int OVS = 16;
    localparam int MID = (OVS / 2 < 1) ? 1 : OVS / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       brg_full = 1'b0;
    logic       iocs = 1'b0;
    logic       iorw = 1'b0;
    logic [1:0] ioaddr = 2'b00;
    logic [7:0] databus = 8'h00;
    logic       tbr, txd, tx_busy, tx_done, ovf;
    logic [3:0] fifo_count;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo #(
        .DATA_W(DW),
        .FIFO_DEPTH(DEP),
        .OVS(OVS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .brg_full(brg_full),
        .iocs(iocs),
        .iorw(iorw),
        .ioaddr(ioaddr),
        .databus(databus),
        .tbr(tbr),
        .txd(txd),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .fifo_count(fifo_count),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        iocs = 1'b1;
        iorw = 1'b0;
        ioaddr = a;
        databus = d;
        tick();
        iocs = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while ((tx_busy !== 1'b0 || fifo_count !== 4'd0) && n < lim) begin
            tick();
            n++;
        end
        chk("wait_idle busy/count", {27'd0, tx_busy, fifo_count}, 32'd0);
    endtask

    // Called on the sample right after the edge that enters START.
    task automatic frame_check(input logic [7:0] d, input logic pen,
                               input logic pbit, input int nstop);
        logic eb [0:11];
        int n;
        int bad;
        n = 0;
        eb[n] = 1'b0;
        n++;
        for (int i = 0; i < DW; i++) begin
            eb[n] = d[i];
            n++;
        end
        if (pen) begin
            eb[n] = pbit;
            n++;
        end
        for (int s = 0; s < nstop; s++) begin
            eb[n] = 1'b1;
            n++;
        end
        for (int b = 0; b < n; b++) begin
            bad = 0;
            for (int c = 0; c < OVS; c++) begin
                if (txd !== eb[b] || tx_busy !== 1'b1) bad++;
                if (!(b == 0 && c == 0) && tx_done !== 1'b0) bad++;
                tick();
            end
            chk($sformatf("frame %02h bit %0d", d, b), bad, 0);
        end
        chk($sformatf("frame %02h tx_done", d), {31'd0, tx_done}, 32'd1);
    endtask

    typedef struct {
        logic [2:0] ctrl;
        logic [7:0] data;
        int         nbits;
        logic       par;
    } vec_t;

    // Receiver model used during the random phase
    logic       mon_en = 1'b0;
    logic       m_act = 1'b0;
    logic       m_done_chk = 1'b0;
    logic       m_pen = 1'b0;
    logic       m_odd = 1'b0;
    int         m_nbits = 10;
    int         m_cnt = 0;
    int         m_bit = 0;
    logic       m_bits [0:11];
    logic [7:0] exp_q [$];

    task automatic rx_frame();
        logic [7:0] d;
        logic [7:0] e;
        int sp;
        for (int i = 0; i < DW; i++) d[i] = m_bits[i + 1];
        chk("rx start bit", {31'd0, m_bits[0]}, 32'd0);
        if (exp_q.size() == 0) begin
            chk("rx unexpected frame", {24'd0, d}, 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            chk("rx data", {24'd0, d}, {24'd0, e});
            if (m_pen) chk("rx parity", {31'd0, m_bits[9]}, {31'd0, (^e) ^ m_odd});
        end
        sp = m_pen ? 10 : 9;
        for (int s = sp; s < m_nbits; s++) chk("rx stop", {31'd0, m_bits[s]}, 32'd1);
    endtask

    always @(posedge clk) begin
        if (mon_en) begin
            if (m_done_chk) begin
                m_done_chk = 1'b0;
                chk("rx tx_done", {31'd0, tx_done}, 32'd1);
            end
            if (!m_act && txd === 1'b0) begin
                m_act = 1'b1;
                m_bit = 0;
                m_cnt = 0;
            end
            if (m_act && brg_full) begin
                m_cnt++;
                if (m_cnt == MID) m_bits[m_bit] = txd;
                if (m_cnt == OVS) begin
                    m_cnt = 0;
                    m_bit++;
                    if (m_bit == m_nbits) begin
                        m_act = 1'b0;
                        m_done_chk = 1'b1;
                        rx_frame();
                    end
                end
            end
        end
    end

    initial begin
        vec_t vt [9];
        logic [7:0] rd [2];
        logic [2:0] cfg;
        int bad;
        int r;

        vt[0] = '{3'd0, 8'h7B, 10, 1'b0};
        vt[1] = '{3'd1, 8'hAA, 11, 1'b0};
        vt[2] = '{3'd3, 8'hAA, 11, 1'b1};
        vt[3] = '{3'd1, 8'h01, 11, 1'b1};
        vt[4] = '{3'd3, 8'h01, 11, 1'b0};
        vt[5] = '{3'd4, 8'h55, 11, 1'b0};
        vt[6] = '{3'd7, 8'h80, 12, 1'b0};
        vt[7] = '{3'd5, 8'hFF, 12, 1'b0};
        vt[8] = '{3'd7, 8'h00, 12, 1'b1};

        // Reset values
        repeat (3) tick();
        chk("rst txd", {31'd0, txd}, 32'd1);
        chk("rst tbr", {31'd0, tbr}, 32'd1);
        chk("rst busy", {31'd0, tx_busy}, 32'd0);
        chk("rst done", {31'd0, tx_done}, 32'd0);
        chk("rst count", {28'd0, fifo_count}, 32'd0);
        chk("rst ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b1;
        tick();

        // Single frames, table-driven
        brg_full = 1'b1;
        for (int k = 0; k < 9; k++) begin
            wr(2'b01, {5'd0, vt[k].ctrl});
            wr(2'b00, vt[k].data);
            chk("tbr after write", {31'd0, tbr}, 32'd1);
            tick();
            frame_check(vt[k].data, vt[k].ctrl[0], vt[k].par,
                        vt[k].nbits - 9 - int'(vt[k].ctrl[0]));
            chk("idle after frame", {31'd0, tx_busy}, 32'd0);
            tick();
            chk("done one clk", {31'd0, tx_done}, 32'd0);
        end

        // Back-to-back frames with two stop bits
        wr(2'b01, 8'h04);
        wr(2'b00, 8'h55);
        wr(2'b00, 8'h0F);
        frame_check(8'h55, 1'b0, 1'b0, 2);
        frame_check(8'h0F, 1'b0, 1'b0, 2);
        tick();
        chk("b2b done low", {31'd0, tx_done}, 32'd0);
        chk("b2b idle", {31'd0, tx_busy}, 32'd0);

        // Fill FIFO with brg stalled, overflow, clear, then drain
        wr(2'b01, 8'h00);
        brg_full = 1'b0;
        for (int i = 0; i < 10; i++) wr(2'b00, 8'h10 + 8'(i));
        chk("full count", {28'd0, fifo_count}, 32'd8);
        chk("full tbr", {31'd0, tbr}, 32'd0);
        chk("ovf set", {31'd0, ovf}, 32'd1);
        chk("stall busy", {31'd0, tx_busy}, 32'd1);
        repeat (5) tick();
        chk("stall txd", {31'd0, txd}, 32'd0);
        chk("stall count", {28'd0, fifo_count}, 32'd8);
        wr(2'b01, 8'h80);
        chk("ovf cleared", {31'd0, ovf}, 32'd0);
        chk("ovf clr count", {28'd0, fifo_count}, 32'd8);
        brg_full = 1'b1;
        for (int i = 0; i < 9; i++) frame_check(8'h10 + 8'(i), 1'b0, 1'b0, 1);
        tick();
        chk("drain busy", {31'd0, tx_busy}, 32'd0);
        chk("drain count", {28'd0, fifo_count}, 32'd0);
        chk("drain tbr", {31'd0, tbr}, 32'd1);

        // Asynchronous reset during data bit 3
        rd[0] = 8'h7B;
        rd[1] = 8'h00;
        for (int k = 0; k < 2; k++) begin
            wr(2'b00, rd[k]);
            wr(2'b00, rd[k]);
            repeat (OVS * 4 + 5) tick();
            chk("pre-rst txd", {31'd0, txd}, {31'd0, rd[k][3]});
            chk("pre-rst count", {28'd0, fifo_count}, 32'd1);
            #2;
            rst = 1'b0;
            #1;
            chk("async rst txd", {31'd0, txd}, 32'd1);
            chk("async rst count", {28'd0, fifo_count}, 32'd0);
            chk("async rst tbr", {31'd0, tbr}, 32'd1);
            chk("async rst busy", {31'd0, tx_busy}, 32'd0);
            tick();
            tick();
            rst = 1'b1;
            bad = 0;
            repeat (300) begin
                tick();
                if (txd !== 1'b1 || tx_busy !== 1'b0) bad++;
            end
            chk("no frame after rst", bad, 0);
        end

        // Control write mid-frame only affects the next frame
        wr(2'b01, 8'h00);
        wr(2'b00, 8'hAA);
        tick();
        fork
            begin
                frame_check(8'hAA, 1'b0, 1'b0, 1);
                frame_check(8'hAA, 1'b1, 1'b0, 1);
            end
            begin
                repeat (40) tick();
                wr(2'b01, 8'h01);
                wr(2'b00, 8'hAA);
            end
        join
        tick();
        chk("ctrl-mid idle", {31'd0, tx_busy}, 32'd0);

        // Random traffic against the receiver model
        for (int ph = 0; ph < 4; ph++) begin
            brg_full = 1'b1;
            wait_idle(4000);
            cfg = (ph == 0) ? 3'd0 : 3'($urandom);
            wr(2'b01, {5'd0, cfg});
            m_pen = cfg[0];
            m_odd = cfg[1];
            m_nbits = 10 + int'(cfg[0]) + int'(cfg[2]);
            mon_en = 1'b1;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                brg_full = ($urandom % 3) != 0;
                r = int'($urandom % 32);
                iocs = 1'b0;
                if (r == 0 && tbr === 1'b1) begin
                    iocs = 1'b1;
                    iorw = 1'b0;
                    ioaddr = 2'b00;
                    databus = 8'($urandom);
                    exp_q.push_back(databus);
                end else if (r == 1) begin
                    iocs = 1'b1;
                    iorw = 1'b1;
                    ioaddr = 2'($urandom);
                    databus = 8'($urandom);
                end else if (r == 2) begin
                    iocs = 1'b1;
                    iorw = 1'b0;
                    ioaddr = 2'b10 | 2'($urandom % 2);
                    databus = 8'($urandom);
                end
                tick();
            end
            iocs = 1'b0;
            brg_full = 1'b1;
            wait_idle(4000);
            tick();
            tick();
            mon_en = 1'b0;
            chk("rand queue empty", exp_q.size(), 0);
            chk("rand rx idle", {31'd0, m_act}, 32'd0);
            chk("rand ovf", {31'd0, ovf}, 32'd0);
            exp_q.delete();
            m_act = 1'b0;
            m_done_chk = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the single-byte transmit block. It adds a TX FIFO, configurable data width, runtime-selectable parity and 1/2 stop bits, oversampled bit timing and an overflow flag. It sits on the same iocs/iorw/ioaddr/databus CPU-side bus and is paced by the baud-generator tick brg_full.

Parameters:
DATA_W, 8, data bits per frame (5..8); databus[DATA_W-1:0] used.
FIFO_DEPTH, 8, TX FIFO entries; power of 2, >=2.
OVS, 16, brg_full pulses per bit period (>=1).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset).
brg_full  input  1  baud tick, one-clk pulse at OVS x baud rate.
iocs  input  1  chip select.
iorw  input  1  1 = read, 0 = write; block acts only on write.
ioaddr  input  2  00 = TX data, 01 = control, 10/11 = ignored.
databus  input  8  write data.
tbr  output  1  transmit buffer ready: FIFO not full.
txd  output  1  serial out, idle high.
tx_busy  output  1  frame in progress (state != IDLE).
tx_done  output  1  one-clk pulse at end of the last stop bit.
fifo_count  output  $clog2(FIFO_DEPTH)+1  entries stored.
ovf  output  1  sticky overflow flag.

Behaviour:
- Reset (rst=0, async): txd=1, tbr=1, tx_busy=0, tx_done=0, fifo_count=0, ovf=0, ctrl=0, FSM=IDLE, FIFO flushed. A reset mid-frame forces txd=1 immediately; the frame is abandoned.
- Write strobe: iocs=1 & iorw=0 sampled at a clk rising edge. One push per strobed cycle.
- Data write (ioaddr=00):
  - Not full: push databus[DATA_W-1:0].
  - Full: data dropped, ovf<=1.
  - Full with a same-cycle pop: push accepted.
- Control write (ioaddr=01):
  - ctrl[0]=parity_en, ctrl[1]=odd (0 = even), ctrl[2]=two_stop.
  - databus[7]=1 clears ovf and is not stored.
  - Control writes never touch the FIFO.
- tbr = (fifo_count != FIFO_DEPTH), derived combinationally from registers.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if FIFO non-empty, pop into the shift register, latch ctrl into the frame config, clear the tick and bit counters, and go to START. txd=0 from the next clock.
  - Each bit lasts exactly OVS brg_full pulses. A bit ends on the clock that sees the OVS-th pulse.
  - START -> DATA. DATA shifts out DATA_W bits, LSB first. DATA then goes to PARITY if parity_en, else STOP.
  - PARITY: txd = XOR of data bits, inverted if odd.
  - STOP: txd=1 for 1 bit, or 2 bits if two_stop. At its end, tx_done pulses for 1 clk.
  - After STOP: if FIFO non-empty, go directly to START (pop in the same cycle, no idle gap); else go to IDLE.
- Control changes mid-frame affect only the next frame.
- brg_full=0 indefinitely: FSM holds in its current bit, txd stable.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH or underflows.
- Reads (iorw=1) and ioaddr 10/11 have no effect.

Test Plan:
1. OVS=16, brg_full every clk, default ctrl; write 0x7B -> txd = 0,1,1,0,1,1,1,1,0,1, each held 16 clks. tx_done pulses once, 160 clks after START entry. tbr stays 1.
2. ctrl=0x01 (even parity); write 0xAA -> txd = 0, 0,1,0,1,0,1,0,1, parity 0, stop 1. Repeat with ctrl=0x03 -> parity bit 1.
3. ctrl=0x04; write 0x55, 0x0F back-to-back -> stop high for exactly 32 clks, then next start bit with no gap. Two tx_done pulses.
4. FIFO_DEPTH=8, brg_full held 0, write 10 bytes:
   - First byte is popped into the shifter.
   - Bytes 2..9 fill the FIFO; fifo_count=8, tbr=0.
   - 10th byte is dropped, ovf=1.
   - Control write 0x80 -> ovf=0.
   - Enable brg_full -> all 9 bytes are sent in order.
5. Write 0x7B, assert rst=0 during data bit 3 -> txd=1 asynchronously, fifo_count=0, tbr=1, tx_busy=0. After release, no frame is emitted.
6. Write 0xAA with ctrl=0; write ctrl=0x01 mid-frame -> current frame has no parity bit. A second byte 0xAA is then sent with even parity bit 0.
